bresenham_line_engine: RTL

- Rasterises one line segment per request into a stream of pixel coordinates, one pixel per clock.
- Sits between the line-list sequencer and the VGA framebuffer; x/y drive the framebuffer address and pixel_valid drives its pixel_write.
- Covers all octants, so segment direction and slope are unrestricted.

---
 rtl/bresenham_line_engine.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: one segment per start, one pixel per clock, all octants.
// Optional on-screen clipping of pixel_valid is enabled by defining LINE_CLIP_EN.
module bresenham_line_engine #(
   parameter int unsigned COORD_W = 11,
   parameter int unsigned X_MAX   = 639,
   parameter int unsigned Y_MAX   = 479
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               pixel_valid,
   output logic               busy,
   output logic               done
);

   localparam int unsigned DW = COORD_W + 1;
   localparam int unsigned EW = COORD_W + 2;
`ifdef LINE_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
   state_t state;

   logic [COORD_W-1:0] lx0, ly0, lx1, ly1;
   logic [COORD_W-1:0] major, minor, major_end, dx, dy;
   logic               steep, ystep_up;
   logic signed [EW-1:0] err;

   // Setup math on the latched endpoints
   logic signed [DW-1:0] ddx, ddy, adx, ady;
   logic               steep_c, swap_c;
   logic [COORD_W-1:0] a0, b0, a1, b1, m0, n0, m1, n1, dx_c, dy_c;
   logic signed [EW-1:0] err_init;

   always_comb begin
      ddx = $signed({1'b0, lx1}) - $signed({1'b0, lx0});
      ddy = $signed({1'b0, ly1}) - $signed({1'b0, ly0});
      adx = ddx[DW-1] ? -ddx : ddx;
      ady = ddy[DW-1] ? -ddy : ddy;
      steep_c = ady > adx;
      a0 = steep_c ? ly0 : lx0;
      b0 = steep_c ? lx0 : ly0;
      a1 = steep_c ? ly1 : lx1;
      b1 = steep_c ? lx1 : ly1;
      swap_c = a0 > a1;
      m0 = swap_c ? a1 : a0;
      n0 = swap_c ? b1 : b0;
      m1 = swap_c ? a0 : a1;
      n1 = swap_c ? b0 : b1;
      dx_c = m1 - m0;
      dy_c = (n1 >= n0) ? n1 - n0 : n0 - n1;
      err_init = -$signed(EW'(dx_c >> 1));
   end

   // Per-pixel step of the minor axis and error term
   logic signed [EW-1:0] err_acc, err_nx;
   logic [COORD_W-1:0] minor_nx, out_x, out_y;
   logic               pix_on;

   always_comb begin
      err_acc  = err + $signed(EW'(dy));
      err_nx   = err_acc;
      minor_nx = minor;
      if (!err_acc[EW-1]) begin
         err_nx   = err_acc - $signed(EW'(dx));
         minor_nx = ystep_up ? minor + COORD_W'(1) : minor - COORD_W'(1);
      end
      out_x  = steep ? minor : major;
      out_y  = steep ? major : minor;
      pix_on = !CLIP || ((32'(out_x) <= X_MAX) && (32'(out_y) <= Y_MAX));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         pixel_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         pixel_valid <= 1'b0;
         done        <= 1'b0;
         case (state)
            IDLE: if (start) begin
               lx0   <= x0;
               ly0   <= y0;
               lx1   <= x1;
               ly1   <= y1;
               busy  <= 1'b1;
               state <= SETUP;
            end
            SETUP: begin
               steep     <= steep_c;
               major     <= m0;
               minor     <= n0;
               major_end <= m1;
               dx        <= dx_c;
               dy        <= dy_c;
               ystep_up  <= (n1 >= n0);
               err       <= err_init;
               state     <= DRAW;
            end
            DRAW: begin
               x           <= out_x;
               y           <= out_y;
               pixel_valid <= pix_on;
               err         <= err_nx;
               minor       <= minor_nx;
               major       <= major + COORD_W'(1);
               if (major == major_end) state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
